// File: rtl/background_difference_if.sv
`default_nettype none
// ============================================================================
//  Module   : background_difference_if
//  Purpose  : Pixel-pair inputs and foreground-mask outputs of the detector.
//  Revision : 1.0  initial release
// ============================================================================
interface background_difference_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] luma_bg;
    logic [DATA_WIDTH-1:0] luma_sign;
    logic                  object_image;
    logic [DATA_WIDTH-1:0] diff_mag;
    logic                  out_valid;

    modport master (
        output luma_bg,
        output luma_sign,
        input  object_image,
        input  diff_mag,
        input  out_valid
    );

    modport slave (
        input  luma_bg,
        input  luma_sign,
        output object_image,
        output diff_mag,
        output out_valid
    );
endinterface
`default_nettype wire

// File: rtl/background_difference.sv
`default_nettype none
// ============================================================================
//  Module   : background_difference
//  Purpose  : Per-pixel |bg - live| luma magnitude and thresholded object mask,
//             registered with one clock of latency.
//  Revision : 1.0  initial release
// ============================================================================
module background_difference #(
    parameter int DATA_WIDTH = 8,
    parameter int THRESHOLD  = 20
) (
    input  wire logic               clk,
    input  wire logic               rst,
    background_difference_if.slave  pix
);
    localparam logic [DATA_WIDTH:0] c_threshold = (DATA_WIDTH + 1)'(THRESHOLD);

    logic [DATA_WIDTH:0]   w_bg_ext;
    logic [DATA_WIDTH:0]   w_sign_ext;
    logic [DATA_WIDTH:0]   w_diff_wide;
    logic                  w_object;

    logic                  r_object_image;
    logic [DATA_WIDTH-1:0] r_diff_mag;
    logic                  r_out_valid;

    // Larger minus smaller in one extra bit, so the result never wraps.
    always_comb begin
        w_bg_ext   = {1'b0, pix.luma_bg};
        w_sign_ext = {1'b0, pix.luma_sign};
        if (w_bg_ext >= w_sign_ext) begin
            w_diff_wide = w_bg_ext - w_sign_ext;
        end else begin
            w_diff_wide = w_sign_ext - w_bg_ext;
        end
        w_object = (w_diff_wide > c_threshold);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_object_image <= 1'b0;
            r_diff_mag     <= '0;
            r_out_valid    <= 1'b0;
        end else begin
            r_object_image <= w_object;
            r_diff_mag     <= w_diff_wide[DATA_WIDTH-1:0];
            r_out_valid    <= 1'b1;
        end
    end

    assign pix.object_image = r_object_image;
    assign pix.diff_mag     = r_diff_mag;
    assign pix.out_valid    = r_out_valid;
endmodule
`default_nettype wire

// File: tb/tb_background_difference.sv
`default_nettype none
// ============================================================================
//  Module   : tb_background_difference
//  Purpose  : Self-checking bench for background_difference.
//  Revision : 1.0  initial release
// ============================================================================
module tb_background_difference;
    localparam int DW  = 8;
    localparam int THR = 20;

    logic clk;
    logic rst;
    int   n_pass;
    int   n_total;

    background_difference_if #(.DATA_WIDTH(DW)) pix ();

    background_difference #(
        .DATA_WIDTH (DW),
        .THRESHOLD  (THR)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .pix (pix)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] bg;
        logic [DW-1:0] sg;
        logic          exp_obj;
        logic [DW-1:0] exp_diff;
    } vec_t;

    vec_t vecs[10];

    task automatic chk(input string name, input int actual, input int required);
        n_total++;
        if (actual == required) begin
            n_pass++;
        end else begin
            $display("FAIL %s actual=%0d required=%0d", name, actual, required);
        end
    endtask

    // Reference: absolute difference of the two unsigned samples, mask when strictly above threshold.
    function automatic int ref_diff(input int a, input int b);
        return (a > b) ? (a - b) : (b - a);
    endfunction

    task automatic apply(input logic [DW-1:0] bg, input logic [DW-1:0] sg);
        @(negedge clk);
        pix.luma_bg   = bg;
        pix.luma_sign = sg;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_and_check(input string name, input logic [DW-1:0] bg, input logic [DW-1:0] sg);
        int d;
        apply(bg, sg);
        d = ref_diff(int'(bg), int'(sg));
        chk({name, "_diff"},  int'(pix.diff_mag),     d);
        chk({name, "_obj"},   int'(pix.object_image), (d > THR) ? 1 : 0);
        chk({name, "_valid"}, int'(pix.out_valid),    1);
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        rst           = 1'b0;
        pix.luma_bg   = '0;
        pix.luma_sign = '0;

        vecs[0] = '{8'd100, 8'd100, 1'b0, 8'd0};
        vecs[1] = '{8'd101, 8'd100, 1'b0, 8'd1};
        vecs[2] = '{8'd100, 8'd100, 1'b0, 8'd0};
        vecs[3] = '{8'd100, 8'd120, 1'b0, 8'd20};
        vecs[4] = '{8'd100, 8'd121, 1'b1, 8'd21};
        vecs[5] = '{8'd121, 8'd100, 1'b1, 8'd21};
        vecs[6] = '{8'd0,   8'd255, 1'b1, 8'd255};
        vecs[7] = '{8'd255, 8'd0,   1'b1, 8'd255};
        vecs[8] = '{8'd255, 8'd255, 1'b0, 8'd0};
        vecs[9] = '{8'd120, 8'd100, 1'b0, 8'd20};

        // Reset held with clock running, inputs nonzero to expose any leakage.
        pix.luma_bg   = 8'd0;
        pix.luma_sign = 8'd255;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_obj",   int'(pix.object_image), 0);
        chk("rst_diff",  int'(pix.diff_mag),     0);
        chk("rst_valid", int'(pix.out_valid),    0);

        @(negedge clk);
        rst = 1'b1;

        for (int i = 0; i < 10; i++) begin
            apply(vecs[i].bg, vecs[i].sg);
            chk($sformatf("vec%0d_diff", i),  int'(pix.diff_mag),     int'(vecs[i].exp_diff));
            chk($sformatf("vec%0d_obj", i),   int'(pix.object_image), int'(vecs[i].exp_obj));
            chk($sformatf("vec%0d_valid", i), int'(pix.out_valid),    1);
        end

        // Outputs hold between edges.
        #3;
        chk("hold_diff", int'(pix.diff_mag), 20);

        for (int i = 0; i < 200; i++) begin
            logic [DW-1:0] a;
            logic [DW-1:0] b;
            a = DW'($urandom_range(255, 0));
            if (i % 4 == 0) begin
                b = DW'($urandom_range(255, 0));
            end else begin
                // Bias toward the threshold neighbourhood.
                b = DW'((int'(a) + int'($urandom_range(2 * THR + 4, 0)) - (THR + 2)) & 8'hff);
            end
            apply_and_check($sformatf("rnd%0d", i), a, b);
        end

        // Asynchronous reset mid-stream.
        apply_and_check("pre_async", 8'd0, 8'd255);
        chk("pre_async_obj_set", int'(pix.object_image), 1);
        #2;
        rst = 1'b0;
        #1;
        chk("async_obj",   int'(pix.object_image), 0);
        chk("async_diff",  int'(pix.diff_mag),     0);
        chk("async_valid", int'(pix.out_valid),    0);
        @(posedge clk);
        #1;
        chk("async_hold_obj",   int'(pix.object_image), 0);
        chk("async_hold_valid", int'(pix.out_valid),    0);
        @(negedge clk);
        rst = 1'b1;
        apply_and_check("post_async", 8'd100, 8'd121);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end
endmodule
`default_nettype wire

// File: doc/background_difference.md
Name: background_difference

Overview:
- Per-pixel foreground detector for the gesture-recognition video path.
- Compares the luma of the live sign-capture pixel against the stored background luma for the same pixel position.
- Emits a registered 1-bit object mask (1 = hand/object, 0 = background) for the downstream binary-image/segmentation stage.
- One pixel pair per clock; fully pipelined; no stalls.

Parameters:
- DATA_WIDTH, 8, bit width of each luma sample.
- THRESHOLD, 20, minimum absolute luma difference that counts as object; a pixel is object only when the difference is strictly greater than THRESHOLD. Legal range 0 .. 2^DATA_WIDTH-1.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
- luma_bg  input  DATA_WIDTH  background luma sample (unsigned).
- luma_sign  input  DATA_WIDTH  live sign-capture luma sample (unsigned).
- object_image  output  1  registered foreground mask bit.
- diff_mag  output  DATA_WIDTH  registered absolute difference |luma_bg - luma_sign|, for debug and tuning.
- out_valid  output  1  high once the output registers hold a real sample since reset release.

Behaviour:
- Reset (rst = 0, asynchronous, no clock needed): object_image = 0, diff_mag = 0, out_valid = 0. All three outputs hold while rst stays low.
- Sampling: on every rising clk edge with rst = 1, the block samples luma_bg and luma_sign.
- Difference computation:
  - Unsigned subtraction in DATA_WIDTH+1 bits, larger minus smaller, so there is no wrap-around.
  - The magnitude always fits in DATA_WIDTH bits (max 255 for 8-bit).
- Decision: object = 1 when the magnitude > THRESHOLD, otherwise 0. Equality counts as background.
- Latency: exactly 1 clock.
  - object_image and diff_mag update on the same edge that samples the inputs.
  - They hold that value until the next edge.
- Purely combinational path from inputs to registers. No other internal state and no dependence on history.
- out_valid:
  - Set to 1 on the first rising edge after rst deasserts.
  - Stays 1 until the next reset.
- Operand order is irrelevant: swapping luma_bg and luma_sign gives identical outputs (symmetric).
- Unknown or X inputs are not filtered; the outputs follow the combinational result.
- Reset asserted mid-stream clears all outputs immediately. The first post-reset output reflects the inputs present at the first active edge.
- Inputs are expected to be driven away from the sampling edge. The bench samples outputs after the edge has settled.

Test Plan:
- Reset: hold rst = 0 with the clock running -> object_image = 0, diff_mag = 0, out_valid = 0. Release rst -> out_valid = 1 after the first edge.
- Equal pixels: luma_bg = 100, luma_sign = 100 -> after 1 clock, object_image = 0, diff_mag = 0.
- Small noise: luma_bg = 101, luma_sign = 100 -> object_image = 0, diff_mag = 1. Then 100/100 back-to-back -> stays 0, diff_mag = 0.
- Threshold boundary (THRESHOLD = 20):
  - 100/120 -> diff 20, object_image = 0.
  - 100/121 -> diff 21, object_image = 1.
  - 121/100 -> object_image = 1 (symmetry).
- Extremes:
  - 0/255 -> diff_mag = 255, object_image = 1.
  - 255/0 -> same.
  - 255/255 -> 0, 0.
- Async reset mid-stream: drive 0/255 so that object_image = 1, then pulse rst low between edges -> object_image and out_valid drop to 0 immediately, without a clock edge.
